// File: rtl/remapper_pkg.sv
// remapper_pkg: shared types and constants for the remapper output buffer.
//   PIX_W       pixel width carried in each buffered beat
//   DROP_CNT_W  width of the saturating drop counter
//   axis_beat_t one FIFO entry {tuser, tlast, tdata}
//   chk_state_t frame geometry checker states
package remapper_pkg;
    localparam int PIX_W = 8;
    localparam int DROP_CNT_W = 16;
    typedef struct packed {
        logic             tuser;
        logic             tlast;
        logic [PIX_W-1:0] tdata;
    } axis_beat_t;
    typedef enum logic {S_IDLE, S_ACTIVE} chk_state_t;
endpackage

// File: rtl/remapper_axis_out_buffer_if.sv
// remapper_axis_out_buffer_if: AXI4-Stream video bundle.
//   tdata/tvalid/tuser/tlast driven by the master, tready driven by the slave.
interface remapper_axis_out_buffer_if
    import remapper_pkg::*;
#(
    parameter int DW = PIX_W
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tuser;
    logic          tlast;
    logic          tready;
    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/remapper_sync_fifo.sv
// remapper_sync_fifo: synchronous FIFO with a registered first-word-fall-through output.
//   i_clk, i_aresetn      clock, synchronous active-low reset
//   wr_en, wr_data        write (caller guarantees space or a same-cycle rd_en)
//   rd_en                 consume the beat in the output register (only while rd_valid)
//   rd_data, rd_valid     registered head of the FIFO
//   full, level           occupancy, counting the output register
module remapper_sync_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 10,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    mem_cnt_q, mem_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             load;

    // A beat written at one edge becomes readable only at the next edge,
    // since the load uses the memory count from before this edge's write.
    always_comb begin
        load        = (mem_cnt_q != '0) && (!out_valid_q || rd_en);
        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_cnt_d   = mem_cnt_q + LW'(wr_en) - LW'(load);
        out_valid_d = load || (out_valid_q && !rd_en);
        out_data_d  = load ? mem[rd_ptr_q] : out_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign level    = mem_cnt_q + LW'(out_valid_q);
    assign full     = level == LW'(DEPTH);
    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
endmodule

// File: rtl/remapper_axis_out_buffer.sv
// remapper_axis_out_buffer: absorbs unthrottled AXI4-Stream video into a FIFO and
// re-emits it with full handshaking, checking frame geometry on the output side.
//   i_clk, i_aresetn     clock, synchronous active-low reset
//   WIDTH, HEIGHT        expected frame geometry (static during a frame)
//   i_clear_status       pulse clearing sticky flags and the drop counter
//   s_axis               input stream (never stalled; tready tied high)
//   m_axis               output stream toward the DMA
//   o_level              beats held, including the output register
//   o_overflow/o_drop_cnt  dropped-beat status
//   o_line_err/o_frame_err/o_frame_cnt  geometry checker status
module remapper_axis_out_buffer
    import remapper_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int FIFO_DEPTH = 256,
    parameter int LEVEL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_aresetn,
    input  logic [12:0]               WIDTH,
    input  logic [12:0]               HEIGHT,
    input  logic                      i_clear_status,
    remapper_axis_out_buffer_if.slave  s_axis,
    remapper_axis_out_buffer_if.master m_axis,
    output logic [LEVEL_W-1:0]        o_level,
    output logic                      o_overflow,
    output logic [DROP_CNT_W-1:0]     o_drop_cnt,
    output logic                      o_line_err,
    output logic                      o_frame_err,
    output logic [15:0]               o_frame_cnt
);
    localparam int FLW = $clog2(FIFO_DEPTH) + 1;

    axis_beat_t            wr_beat, rd_beat;
    logic                  rd_valid, fifo_full, push, pop, drop;
    logic [FLW-1:0]        fifo_level;
    chk_state_t            state_q, state_d;
    logic [12:0]           x_q, x_d, y_q, y_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  line_set, frame_set, geo_ok, last_col;

    // Upstream cannot be stalled; excess beats are dropped instead.
    assign s_axis.tready = 1'b1;

    always_comb begin
        wr_beat.tuser = s_axis.tuser;
        wr_beat.tlast = s_axis.tlast;
        wr_beat.tdata = s_axis.tdata;
    end

    assign pop  = rd_valid && m_axis.tready;
    assign push = s_axis.tvalid && (!fifo_full || pop);
    assign drop = s_axis.tvalid && fifo_full && !pop;

    remapper_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(axis_beat_t))
    ) u_fifo (
        .i_clk    (i_clk),
        .i_aresetn(i_aresetn),
        .wr_en    (push),
        .wr_data  (wr_beat),
        .rd_en    (pop),
        .rd_data  (rd_beat),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign m_axis.tvalid = rd_valid;
    assign m_axis.tdata  = rd_beat.tdata;
    assign m_axis.tuser  = rd_beat.tuser;
    assign m_axis.tlast  = rd_beat.tlast;
    assign o_level       = LEVEL_W'(fifo_level);

    // Geometry checker on popped beats. A start-of-frame beat is column 0;
    // with WIDTH==1 and tlast it also closes line 0 immediately.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        line_set    = 1'b0;
        frame_set   = 1'b0;
        geo_ok      = (WIDTH != '0) && (HEIGHT != '0);
        last_col    = x_q == WIDTH - 13'd1;
        if (!geo_ok) begin
            state_d = S_IDLE;
        end else if (pop) begin
            if (rd_beat.tuser) begin
                frame_set = state_q == S_ACTIVE;
                if (WIDTH == 13'd1 && rd_beat.tlast) begin
                    x_d     = '0;
                    y_d     = (HEIGHT == 13'd1) ? 13'd0 : 13'd1;
                    state_d = (HEIGHT == 13'd1) ? S_IDLE : S_ACTIVE;
                    frame_cnt_d = (HEIGHT == 13'd1) ? frame_cnt_q + 16'd1 : frame_cnt_q;
                end else begin
                    x_d     = 13'd1;
                    y_d     = '0;
                    state_d = S_ACTIVE;
                end
            end else if (state_q == S_IDLE) begin
                frame_set = 1'b1;
            end else begin
                // Any line end (expected or early tlast) resyncs to the next line.
                line_set = rd_beat.tlast != last_col;
                if (rd_beat.tlast || last_col) begin
                    x_d = '0;
                    if (y_q == HEIGHT - 13'd1) begin
                        y_d         = '0;
                        state_d     = S_IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        y_d = y_q + 13'd1;
                    end
                end else begin
                    x_d = x_q + 13'd1;
                end
            end
        end
    end

    // A new event in the clear cycle wins over the clear.
    always_comb begin
        overflow_d  = drop || (overflow_q && !i_clear_status);
        line_err_d  = line_set || (line_err_q && !i_clear_status);
        frame_err_d = frame_set || (frame_err_q && !i_clear_status);
        drop_cnt_d  = i_clear_status ? DROP_CNT_W'(drop) :
                      (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_line_err  = line_err_q;
    assign o_frame_err = frame_err_q;
    assign o_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_remapper_axis_out_buffer.sv
// tb_remapper_axis_out_buffer: directed and random stimulus against a queue-based reference.
module tb_remapper_axis_out_buffer;
    import remapper_pkg::*;
    localparam int D = 8;
    localparam int LW = 4;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic [12:0] w = 13'd4, h = 13'd3;
    logic [LW-1:0] level;
    logic ovf, lerr, ferr;
    logic [15:0] dcnt, fcnt;

    remapper_axis_out_buffer_if #(.DW(8)) s_if ();
    remapper_axis_out_buffer_if #(.DW(8)) m_if ();

    remapper_axis_out_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(D), .LEVEL_W(LW)) dut (
        .i_clk(clk), .i_aresetn(rst_n), .WIDTH(w), .HEIGHT(h), .i_clear_status(clr),
        .s_axis(s_if), .m_axis(m_if), .o_level(level), .o_overflow(ovf),
        .o_drop_cnt(dcnt), .o_line_err(lerr), .o_frame_err(ferr), .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         t;
    } ent_t;

    ent_t q[$];
    int edge_n = 0, errors = 0, checks = 0;
    int m_dcnt = 0, m_col = 0, m_row = 0;
    bit m_ovf = 0, m_lerr = 0, m_ferr = 0, m_act = 0;
    logic [15:0] m_fcnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A beat becomes visible at the output one edge after the edge that stored it.
    function automatic bit head_vis();
        return q.size() > 0 && q[0].t < edge_n;
    endfunction

    // Frame geometry: position within the current line/frame, tracked as plain integers.
    task automatic geo(input ent_t b);
        int wi = int'(w), hi = int'(h);
        bit lc;
        if (wi == 0 || hi == 0) begin
            m_act = 0;
            return;
        end
        if (b.u) begin
            if (m_act) m_ferr = 1;
            m_row = 0;
            m_col = 1;
            m_act = 1;
            if (wi == 1 && b.l) begin
                m_col = 0;
                m_row = 1;
                if (hi == 1) begin
                    m_fcnt++;
                    m_act = 0;
                    m_row = 0;
                end
            end
        end else if (!m_act) begin
            m_ferr = 1;
        end else begin
            lc = m_col == wi - 1;
            if (b.l != lc) m_lerr = 1;
            if (b.l || lc) begin
                m_col = 0;
                m_row++;
                if (m_row == hi) begin
                    m_fcnt++;
                    m_act = 0;
                    m_row = 0;
                end
            end else m_col++;
        end
    endtask

    task automatic check_outputs();
        bit v = head_vis();
        chk("tvalid", m_if.tvalid, v);
        if (v) chk("beat", {m_if.tuser, m_if.tlast, m_if.tdata}, {q[0].u, q[0].l, q[0].d});
        chk("level", level, q.size());
        chk("overflow", ovf, m_ovf);
        chk("drop_cnt", dcnt, m_dcnt);
        chk("line_err", lerr, m_lerr);
        chk("frame_err", ferr, m_ferr);
        chk("frame_cnt", fcnt, m_fcnt);
    endtask

    task automatic apply_model();
        bit v = head_vis();
        bit pop, drop;
        edge_n++;
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_dcnt = 0; m_lerr = 0; m_ferr = 0; m_fcnt = '0;
            m_act = 0; m_col = 0; m_row = 0;
            return;
        end
        pop = v && m_if.tready;
        drop = s_if.tvalid && !pop && q.size() == D;
        if (clr) begin
            m_ovf = 0; m_dcnt = 0; m_lerr = 0; m_ferr = 0;
        end
        if (drop) begin
            m_ovf = 1;
            if (m_dcnt < 65535) m_dcnt++;
        end
        if (pop) geo(q.pop_front());
        if (s_if.tvalid && !drop) q.push_back('{s_if.tdata, s_if.tuser, s_if.tlast, edge_n});
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        apply_model();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic u, input logic l);
        s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, 10'd0);
        chk("rst_level", level, 4'd0);
        rst_n = 1'b1;

        // clean 4x3 frame, data 0..11, tready high
        m_if.tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            beat(8'(i), i == 0, i % 4 == 3);
            if (i == 0) chk("first_gap", m_if.tvalid, 1'b0);
            if (i == 1) chk("first_out", {m_if.tvalid, m_if.tdata}, 9'h100);
        end
        idle(4);
        chk("clean_fcnt", fcnt, 16'd1);
        chk("clean_flags", {ovf, lerr, ferr}, 3'b000);

        // overflow: 10 beats into a depth-8 FIFO with tready low
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 10; i++) beat(8'($urandom), i == 0, i % 4 == 3);
        chk("ovf_level", level, 4'd8);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_drops", dcnt, 16'd2);
        m_if.tready = 1'b1;
        idle(10);

        // full FIFO with push and pop every cycle: no drops, level pinned
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 8; i++) beat(8'($urandom), i == 0, i % 4 == 3);
        m_if.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            beat(8'($urandom), 1'b0, i % 4 == 3);
            chk("full_level", level, 4'd8);
        end
        chk("full_nodrop", dcnt, 16'd0);
        idle(12);

        // early tlast on 3rd beat of line 0, then clean lines
        do_reset();
        for (int i = 0; i < 3; i++) beat(8'(i), i == 0, i == 2);
        for (int i = 0; i < 8; i++) beat(8'(i + 3), 1'b0, i % 4 == 3);
        idle(4);
        chk("lerr_set", lerr, 1'b1);
        chk("lerr_noferr", ferr, 1'b0);
        chk("lerr_fcnt", fcnt, 16'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("lerr_clr", lerr, 1'b0);

        // tuser reasserted mid line 1; the restarted frame completes
        do_reset();
        for (int i = 0; i < 5; i++) beat(8'(i), i == 0, i == 3);
        for (int i = 0; i < 12; i++) beat(8'(i + 5), i == 0, i % 4 == 3);
        idle(4);
        chk("ferr_set", ferr, 1'b1);
        chk("ferr_fcnt", fcnt, 16'd1);

        // zero geometry: checker ignores everything
        do_reset();
        w = 13'd0;
        for (int i = 0; i < 6; i++) beat(8'($urandom), 1'($urandom), 1'($urandom));
        idle(4);
        chk("zero_geo", {lerr, ferr, fcnt}, 18'd0);
        w = 13'd4;

        // random traffic, backpressure bursts, occasional clears
        do_reset();
        w = 13'd3;
        h = 13'd2;
        for (int i = 0; i < 600; i++) begin
            m_if.tready = ((i / 50) % 3 == 1) ? 1'b0 : ($urandom % 3 != 0);
            clr = ($urandom % 50 == 0);
            if ($urandom % 4 != 0) beat(8'($urandom), $urandom % 8 == 0, $urandom % 3 == 0);
            else idle(1);
        end
        clr = 1'b0;
        m_if.tready = 1'b1;
        idle(12);
        w = 13'd4;
        h = 13'd3;

        // reset with 5 beats buffered: nothing stale afterwards
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) beat(8'(i + 1), i == 0, 1'b0);
        chk("pre_rst_level", level, 4'd5);
        do_reset();
        chk("mid_rst_tvalid", m_if.tvalid, 1'b0);
        chk("mid_rst_level", level, 4'd0);
        chk("mid_rst_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, 10'd0);
        chk("mid_rst_flags", {ovf, lerr, ferr, dcnt, fcnt}, 35'd0);
        m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("no_stale", m_if.tvalid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/remapper_axis_out_buffer.md
Name: remapper_axis_out_buffer

Overview:
- Downstream stage of the 12K remapper top. Its m_axis output has no tready, so this block absorbs that unthrottled AXI4-Stream video.
- Buffers beats in a synchronous FIFO and re-emits them on a fully handshaked AXI4-Stream master toward the DMA/VDMA.
- Checks frame geometry against WIDTH/HEIGHT on the output side and exposes sticky status: overflow, line error, frame error, frame count.

Parameters:
- DATA_WIDTH, 8, pixel width.
- FIFO_DEPTH, 256, FIFO entries; power of two, at least 4.
- LEVEL_W, $clog2(FIFO_DEPTH)+1, width of the level output.

Ports:
- i_clk  in  1  clock.
- i_aresetn  in  1  reset. Synchronous, active-low, sampled on rising i_clk.
- WIDTH  in  13  pixels per line. Static while a frame is in flight.
- HEIGHT  in  13  lines per frame. Static while a frame is in flight.
- i_clear_status  in  1  one-cycle pulse; clears the sticky flags and the drop counter.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input beat valid. Upstream cannot stall.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tuser  out  1  start of frame.
- m_axis_tlast  out  1  end of line.
- m_axis_tready  in  1  downstream ready.
- o_level  out  LEVEL_W  current FIFO occupancy.
- o_overflow  out  1  sticky: at least one beat dropped.
- o_drop_cnt  out  16  dropped beats; saturates at 16'hFFFF.
- o_line_err  out  1  sticky: tlast misplaced or missing.
- o_frame_err  out  1  sticky: tuser misplaced or frame truncated.
- o_frame_cnt  out  16  completed frames output; wraps.

Behaviour:
- Reset (i_aresetn=0 at a clock edge):
  - FIFO flushed; o_level=0.
  - All m_axis outputs 0.
  - All flags and counters 0; checker in S_IDLE.
  - A reset in mid-frame discards buffered beats. No partial beat is emitted afterwards.
- Storage: each entry is {tuser, tlast, tdata}.
- Push: occurs when s_axis_tvalid=1 and (level<FIFO_DEPTH, or a pop occurs in the same cycle).
  - Push when full with a simultaneous pop: accepted, level unchanged.
- Drop: s_axis_tvalid=1 while full with no pop.
  - Beat discarded; o_overflow<=1.
  - o_drop_cnt increments, saturating.
- Pop: m_axis_tvalid && m_axis_tready.
- Output:
  - m_axis_* are registered; latency is 1 cycle. A beat pushed into an empty FIFO at edge N is valid after edge N+1.
  - Throughput is 1 beat/clk when tready is held high.
  - While tvalid=1 and tready=0, tdata, tuser and tlast hold stable (AXI rule).
- o_level counts every beat accepted and not yet popped, including the beat in the output register.
- i_clear_status vs. a same-cycle event: the new event wins and the flag sets. For o_drop_cnt, the count loads 1 if a drop coincides with the clear.
- Checker: operates on popped beats only. Counters x, y are 13 bits each.
  - S_IDLE:
    - Popped beat with tuser=1 → x=1 (or x=0, y=1 if WIDTH==1 and tlast); go to S_ACTIVE.
    - Popped beat with tuser=0 → o_frame_err<=1; stay in S_IDLE.
  - S_ACTIVE, per pop:
    - tuser=1 → o_frame_err<=1. The beat restarts the frame (x, y reset as in S_IDLE).
    - tlast=1 with x!=WIDTH-1 → o_line_err<=1. Resync: x=0, y++.
    - x==WIDTH-1 with tlast=0 → o_line_err<=1. x=0, y++.
    - Correct tlast at x==WIDTH-1 → x=0, y++.
    - When the line-ending pop has y==HEIGHT-1 → o_frame_cnt++; go to S_IDLE.
    - Otherwise x++.
- WIDTH or HEIGHT of 0 is illegal. With either at 0 the checker stays in S_IDLE, ignores tuser, and raises no errors.

Decomposition:
- Package remapper_pkg holds:
  - typedef axis_beat_t, a packed struct {tuser, tlast, tdata}. DATA_WIDTH comes from the package constant PIX_W=8.
  - typedef enum chk_state_t {S_IDLE, S_ACTIVE}.
  - Constant DROP_CNT_W=16.
- One sub-module, remapper_sync_fifo:
  - Parameters DEPTH and WIDTH; push/pop interface with full/empty/level.
  - Registered first-word-fall-through output; synchronous active-low reset.
- The checker stays inline in remapper_axis_out_buffer.

Test Plan:
- WIDTH=4, HEIGHT=3, tready=1, one clean 12-beat frame (data 0..11) → output identical, first beat 1 cycle after input; o_frame_cnt=1; no flags set.
- FIFO_DEPTH=8, tready=0, 10 consecutive valid beats → o_level=8, o_overflow=1, o_drop_cnt=2. Then tready=1 → exactly the first 8 beats emerge in order.
- Full FIFO, tready=1, input valid every cycle for 20 cycles → no drops; o_level stays 8.
- WIDTH=4, tlast on the 3rd beat of line 0 → o_line_err=1; the next line checks correctly. i_clear_status → flag 0 next cycle.
- tuser reasserted mid-line 1 of a WIDTH=4, HEIGHT=3 frame → o_frame_err=1; the restarted frame completes and o_frame_cnt increments by 1.
- Reset asserted with 5 beats buffered → after reset m_axis_tvalid=0, o_level=0, all flags 0, and no stale beats emerge.
